multicycle_controller: RTL and testbench

Multi-cycle control FSM for the 32-bit MIPS-subset datapath. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. Mux selects are decoded from a latched opcode/funct, and the PC, IR, register-file and data-memory write enables are gated per state. It replaces the single-cycle controller. The datapath shares one ALU across states and needs an instruction-register write enable (IRWrite) and a PC write enable (PCWrite).

---
 rtl/multicycle_controller.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM (FETCH, DECODE, EXEC, MEM, WB) for the 32-bit MIPS-subset datapath.
// Later states decode only from the Op/Func copy captured in DECODE; all outputs are low while Reset is high.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Zero,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             RegA,
    output logic             RegB,
    output logic [3:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IllegalOp,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] alu_decode(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] code;
        code = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_SUB:  code = ALU_SUB;
                FN_AND:  code = ALU_AND;
                FN_OR:   code = ALU_OR;
                FN_SLT:  code = ALU_SLT;
                FN_SLL:  code = ALU_SLL;
                FN_SRL:  code = ALU_SRL;
                default: code = ALU_ADD;
            endcase
        end else if (op == OP_BEQ) begin
            code = ALU_SUB;
        end
        return code;
    endfunction

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       func_q, func_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src;
    logic       reg_a, reg_b, mem_read, mem_write, mem_to_reg, illegal_op;
    logic       is_shift;
    logic [3:0] alu_op;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        func_d     = func_q;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        reg_a      = 1'b0;
        reg_b      = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        is_shift   = (op_q == OP_RTYPE) && ((func_q == FN_SLL) || (func_q == FN_SRL));

        // ALU-facing selects stay put from EXEC to WB so the ALU result is stable for MEM and WB.
        if ((state_q == EXEC) || (state_q == MEM) || (state_q == WB)) begin
            alu_src = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
            reg_a   = is_shift;
            reg_b   = is_shift;
            alu_op  = alu_decode(op_q, func_q);
        end

        case (state_q)
            FETCH: begin
                ir_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                op_d   = Op;
                func_d = Func;
                if (is_legal(Op, Func)) begin
                    state_d = EXEC;
                end else begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = FETCH;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI: state_d = WB;
                    OP_LW, OP_SW:      state_d = MEM;
                    OP_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = Zero;
                        state_d  = FETCH;
                    end
                    default:           state_d = FETCH;
                endcase
            end
            MEM: begin
                if (op_q == OP_LW) begin
                    mem_read = 1'b1;
                    state_d  = WB;
                end else begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                    state_d   = FETCH;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = (op_q == OP_RTYPE);
                mem_to_reg = (op_q == OP_LW);
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        count_d = pc_write ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FETCH;
            op_q    <= '0;
            func_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            func_q  <= func_d;
            count_q <= count_d;
        end
    end

    assign IRWrite    = ir_write   & ~Reset;
    assign PCWrite    = pc_write   & ~Reset;
    assign PCSrc      = pc_src     & ~Reset;
    assign RegDst     = reg_dst    & ~Reset;
    assign RegWrite   = reg_write  & ~Reset;
    assign ALUSrc     = alu_src    & ~Reset;
    assign RegA       = reg_a      & ~Reset;
    assign RegB       = reg_b      & ~Reset;
    assign ALUOp      = Reset ? 4'b0000 : alu_op;
    assign MemRead    = mem_read   & ~Reset;
    assign MemWrite   = mem_write  & ~Reset;
    assign MemtoReg   = mem_to_reg & ~Reset;
    assign IllegalOp  = illegal_op & ~Reset;
    assign State      = Reset ? 3'd0 : state_q;
    assign InstrCount = Reset ? '0 : count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level trace model checked every cycle, plus literal spot checks.
module tb_multicycle_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Op    = 6'h00;
    logic [5:0] Func  = 6'h20;
    logic       Zero  = 1'b0;

    logic        IRWrite, PCWrite, PCSrc, RegDst, RegWrite, ALUSrc, RegA, RegB;
    logic        MemRead, MemWrite, MemtoReg, IllegalOp;
    logic [3:0]  ALUOp;
    logic [2:0]  State;
    logic [31:0] InstrCount;

    logic        w4_IRWrite, w4_PCWrite, w4_PCSrc, w4_RegDst, w4_RegWrite, w4_ALUSrc, w4_RegA, w4_RegB;
    logic        w4_MemRead, w4_MemWrite, w4_MemtoReg, w4_IllegalOp;
    logic [3:0]  w4_ALUOp;
    logic [2:0]  w4_State;
    logic [3:0]  w4_InstrCount;

    multicycle_controller #(.CNT_W(32)) dut (
        .Clock(Clock), .Reset(Reset), .Op(Op), .Func(Func), .Zero(Zero),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .RegA(RegA), .RegB(RegB), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IllegalOp(IllegalOp),
        .State(State), .InstrCount(InstrCount)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .Op(Op), .Func(Func), .Zero(Zero),
        .IRWrite(w4_IRWrite), .PCWrite(w4_PCWrite), .PCSrc(w4_PCSrc), .RegDst(w4_RegDst),
        .RegWrite(w4_RegWrite), .ALUSrc(w4_ALUSrc), .RegA(w4_RegA), .RegB(w4_RegB), .ALUOp(w4_ALUOp),
        .MemRead(w4_MemRead), .MemWrite(w4_MemWrite), .MemtoReg(w4_MemtoReg), .IllegalOp(w4_IllegalOp),
        .State(w4_State), .InstrCount(w4_InstrCount)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef enum {K_R, K_SH, K_ADDI, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: k = K_R;
                    6'h00, 6'h02:                      k = K_SH;
                    default:                           k = K_ILL;
                endcase
            end
            6'h08:   k = K_ADDI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04:   k = K_BEQ;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] c;
        c = 4'b0000;
        if (op == 6'h00) begin
            case (fn)
                6'h22:   c = 4'b0001;
                6'h24:   c = 4'b0010;
                6'h25:   c = 4'b0011;
                6'h2A:   c = 4'b0100;
                6'h00:   c = 4'b1000;
                6'h02:   c = 4'b1001;
                default: c = 4'b0000;
            endcase
        end else if (op == 6'h04) begin
            c = 4'b0001;
        end
        return c;
    endfunction

    // Cycles from FETCH to the next FETCH for each instruction class.
    function automatic int unsigned ilen(input kind_t k);
        case (k)
            K_BEQ:   return 3;
            K_LW:    return 5;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] state_at(input kind_t k, input int unsigned idx);
        if (idx <= 2) return 3'(idx);
        if (idx == 3) return (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
        return 3'd4;
    endfunction

    // Model: position within the current instruction, class captured at its decode cycle, retired count.
    int unsigned m_idx  = 0;
    kind_t       m_kind = K_R;
    logic [5:0]  m_op   = 6'h00;
    logic [5:0]  m_fn   = 6'h00;
    logic [31:0] m_cnt  = 32'd0;

    function automatic kind_t cur_kind();
        return (m_idx == 1) ? classify(Op, Func) : m_kind;
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            m_idx <= 0;
            m_cnt <= 32'd0;
        end else begin
            if (m_idx == 1) begin
                m_kind <= classify(Op, Func);
                m_op   <= Op;
                m_fn   <= Func;
            end
            if (m_idx != 0 && m_idx == ilen(cur_kind()) - 1) begin
                m_idx <= 0;
                m_cnt <= m_cnt + 32'd1;
            end else begin
                m_idx <= m_idx + 1;
            end
        end
    end

    kind_t       c_k;
    logic        e_ir, e_pcw, e_pcs, e_rd, e_rw, e_as, e_sh, e_mr, e_mw, e_m2r, e_ill, e_act;
    logic [3:0]  e_alu;
    logic [2:0]  e_st;
    logic [31:0] e_cnt;

    always @(negedge Clock) begin
        c_k   = cur_kind();
        e_cnt = Reset ? 32'd0 : m_cnt;
        e_st  = Reset ? 3'd0 : state_at(c_k, m_idx);
        e_act = !Reset && m_idx >= 2;
        e_ir  = !Reset && m_idx == 0;
        e_pcw = !Reset && m_idx != 0 && m_idx == ilen(c_k) - 1;
        e_ill = !Reset && c_k == K_ILL && m_idx == 1;
        e_as  = e_act && (c_k == K_ADDI || c_k == K_LW || c_k == K_SW);
        e_sh  = e_act && c_k == K_SH;
        e_alu = e_act ? alu_code(m_op, m_fn) : 4'b0000;
        e_pcs = !Reset && c_k == K_BEQ && m_idx == 2 && Zero;
        e_mr  = !Reset && c_k == K_LW && m_idx == 3;
        e_mw  = !Reset && c_k == K_SW && m_idx == 3;
        e_rw  = e_pcw && (c_k == K_R || c_k == K_SH || c_k == K_ADDI || c_k == K_LW);
        e_rd  = e_rw && (c_k == K_R || c_k == K_SH);
        e_m2r = e_rw && c_k == K_LW;

        chk("State",      32'(State),      32'(e_st));
        chk("InstrCount", InstrCount,      e_cnt);
        chk("IRWrite",    32'(IRWrite),    32'(e_ir));
        chk("PCWrite",    32'(PCWrite),    32'(e_pcw));
        chk("PCSrc",      32'(PCSrc),      32'(e_pcs));
        chk("RegDst",     32'(RegDst),     32'(e_rd));
        chk("RegWrite",   32'(RegWrite),   32'(e_rw));
        chk("ALUSrc",     32'(ALUSrc),     32'(e_as));
        chk("RegA",       32'(RegA),       32'(e_sh));
        chk("RegB",       32'(RegB),       32'(e_sh));
        chk("ALUOp",      32'(ALUOp),      32'(e_alu));
        chk("MemRead",    32'(MemRead),    32'(e_mr));
        chk("MemWrite",   32'(MemWrite),   32'(e_mw));
        chk("MemtoReg",   32'(MemtoReg),   32'(e_m2r));
        chk("IllegalOp",  32'(IllegalOp),  32'(e_ill));
        chk("w4_State",   32'(w4_State),   32'(e_st));
        chk("w4_Count",   32'(w4_InstrCount), 32'(e_cnt[3:0]));
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Called one tick after the edge that enters FETCH; returns one tick after the next FETCH edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        Op   = op;
        Func = fn;
        Zero = z;
        repeat (ilen(classify(op, fn))) step();
    endtask

    task automatic beq_run(input logic z);
        Op   = 6'h04;
        Func = 6'h00;
        Zero = z;
        step();
        step();
        chk("beq_exec_state",  32'(State),   32'd2);
        chk("beq_exec_pcw",    32'(PCWrite), 32'd1);
        chk("beq_exec_pcsrc",  32'(PCSrc),   32'(z));
        chk("beq_exec_aluop",  32'(ALUOp),   32'b0001);
        step();
        chk("beq_back_fetch",  32'(State),   32'd0);
    endtask

    initial begin
        step();
        chk("rst_state",   32'(State),   32'd0);
        chk("rst_cnt",     InstrCount,   32'd0);
        chk("rst_irwrite", 32'(IRWrite), 32'd0);
        step();
        Reset = 1'b0;
        #1;
        chk("fetch_irwrite", 32'(IRWrite), 32'd1);

        run_instr(6'h00, 6'h20, 1'b0);
        chk("add_cnt",   InstrCount,  32'd1);
        chk("add_state", 32'(State),  32'd0);

        run_instr(6'h23, 6'h00, 1'b0);
        chk("lw_cnt", InstrCount, 32'd2);

        beq_run(1'b1);
        beq_run(1'b0);
        chk("beq_cnt", InstrCount, 32'd4);

        Op   = 6'h00;
        Func = 6'h00;
        Zero = 1'b0;
        step();
        step();
        Op = 6'h2B;
        #1;
        chk("sll_state", 32'(State), 32'd2);
        chk("sll_aluop", 32'(ALUOp), 32'b1000);
        chk("sll_rega",  32'(RegA),  32'd1);
        chk("sll_regb",  32'(RegB),  32'd1);
        chk("sll_alusrc", 32'(ALUSrc), 32'd0);
        step();
        chk("sll_wb_state",  32'(State),    32'd4);
        chk("sll_wb_regdst", 32'(RegDst),   32'd1);
        chk("sll_wb_memrd",  32'(MemRead),  32'd0);
        step();
        chk("sll_cnt", InstrCount, 32'd5);

        Op   = 6'h3F;
        Func = 6'h00;
        step();
        chk("ill_pulse", 32'(IllegalOp), 32'd1);
        chk("ill_pcw",   32'(PCWrite),   32'd1);
        chk("ill_state", 32'(State),     32'd1);
        step();
        chk("ill_fetch", 32'(State),     32'd0);
        chk("ill_cnt",   InstrCount,     32'd6);

        Op   = 6'h2B;
        Func = 6'h00;
        step();
        step();
        step();
        chk("sw_mem_write", 32'(MemWrite), 32'd1);
        Reset = 1'b1;
        #1;
        chk("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("sw_rst_pcw",      32'(PCWrite),  32'd0);
        step();
        Reset = 1'b0;
        #1;
        chk("sw_rst_state", 32'(State), 32'd0);
        chk("sw_rst_cnt",   InstrCount, 32'd0);

        repeat (15) run_instr(6'h00, 6'h20, 1'b0);
        chk("wrap_15", 32'(w4_InstrCount), 32'd15);
        run_instr(6'h08, 6'h00, 1'b0);
        chk("wrap_0",   32'(w4_InstrCount), 32'd0);
        chk("wrap_c32", InstrCount,         32'd16);

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
